// File: rtl/axis_s.sv
// AXI-Stream receiver: buffers incoming beats in a first-word-fall-through FIFO,
// drains them on a valid/ready port and reports per-frame length and length errors.
module axis_s #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int EXP_LEN = 40
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              tvalid,
  output logic              tready,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tlast,
  input  logic              enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic [15:0]       frame_len,
  output logic              len_err,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [15:0]      EXP_LEN_W = 16'(EXP_LEN);
  localparam logic [15:0]      LEN_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [DATA_W:0]  mem_q [DEPTH];
  logic [DATA_W:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_len_q, frame_len_d;
  logic             len_err_q, len_err_d;

  logic             push;
  logic             pop;
  logic [DATA_W:0]  head;
  logic [15:0]      len_inc;

  // Ready depends only on registered occupancy, so upstream never sees a path from out_ready or tvalid.
  assign tready    = aresetn & enable & (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = tvalid & tready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_last  = out_valid ? head[DATA_W] : 1'b0;

  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign len_err    = len_err_q;
  assign busy       = (state_q == RECV);

  assign len_inc = (beat_cnt_q == LEN_MAX) ? LEN_MAX : beat_cnt_q + 16'd1;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tlast, tdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame tracking: IDLE and RECV share the same increment since beat_cnt is 0 in IDLE.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    len_err_d    = len_err_q;
    if (push) begin
      if (tlast) begin
        state_d      = IDLE;
        beat_cnt_d   = 16'd0;
        frame_done_d = 1'b1;
        frame_len_d  = len_inc;
        len_err_d    = (len_inc != EXP_LEN_W);
      end else begin
        state_d    = RECV;
        beat_cnt_d = len_inc;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      beat_cnt_q   <= 16'd0;
      frame_done_q <= 1'b0;
      frame_len_q  <= 16'd0;
      len_err_q    <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      len_err_q    <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axis_s.sv
// Self-checking bench for axis_s: a queue-based reference of the receiver is compared
// against the DUT every cycle, alongside directed frame scenarios with literal expectations.
module tb_axis_s;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int EXP_LEN = 40;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              enable;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              frame_done;
  logic [15:0]       frame_len;
  logic              len_err;
  logic              busy;

  int tests = 0;
  int fails = 0;

  axis_s #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EXP_LEN(EXP_LEN)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tlast      (tlast),
    .enable     (enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .len_err    (len_err),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored beats plus a running beat count for the current frame.
  logic [DATA_W:0] mq[$];
  int              m_cnt  = 0;
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  int              m_len  = 0;
  logic            m_err  = 1'b0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mq.delete();
      m_cnt  = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_len  = 0;
      m_err  = 1'b0;
    end else begin
      bit acc;
      bit take;
      acc  = tvalid && enable && (mq.size() < DEPTH);
      take = out_ready && (mq.size() > 0);
      m_done = 1'b0;
      if (take) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({tlast, tdata});
        if (tlast) begin
          m_len  = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
          m_err  = (m_len != EXP_LEN);
          m_done = 1'b1;
          m_cnt  = 0;
          m_busy = 1'b0;
        end else begin
          m_cnt  = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
          m_busy = 1'b1;
        end
      end
    end
  end

  bit              logging = 1'b0;
  int              accepted = 0;
  logic [DATA_W:0] got[$];

  // Compare process: inputs change just after the rising edge, so the falling edge sees settled values.
  always @(negedge aclk) begin
    logic [DATA_W:0] hd;
    hd = (mq.size() > 0) ? mq[0] : '0;
    checkOutput("tready",     32'(tready),     32'(aresetn && enable && (mq.size() < DEPTH)));
    checkOutput("out_valid",  32'(out_valid),  32'(mq.size() > 0));
    checkOutput("out_data",   out_data,        hd[DATA_W-1:0]);
    checkOutput("out_last",   32'(out_last),   32'(hd[DATA_W]));
    checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    checkOutput("frame_len",  32'(frame_len),  32'(m_len));
    checkOutput("len_err",    32'(len_err),    32'(m_err));
    checkOutput("busy",       32'(busy),       32'(m_busy));
    if (logging && aresetn && tvalid && tready) accepted++;
    if (logging && aresetn && out_valid && out_ready) got.push_back({out_last, out_data});
  end

  // Transmitter: sends beats base..base+n-1, holding each until accepted.
  task automatic applyStimulus(input int n, input int base, input int pause_at, input int abort_at);
    for (int i = 0; i < n; i++) begin
      bit timed_out;
      int w;
      if (i == abort_at) break;
      tvalid = 1'b1;
      tdata  = DATA_W'(base + i);
      tlast  = (i == n - 1);
      if (i == pause_at) begin
        enable = 1'b0;
        @(posedge aclk); #1;
        enable = 1'b1;
      end
      timed_out = 1'b0;
      w = 0;
      forever begin
        @(negedge aclk);
        if (tready) break;
        w++;
        if (w > 500) begin
          timed_out = 1'b1;
          break;
        end
      end
      if (timed_out) begin
        fails++;
        tests++;
        $display("[TB] FAIL handshake timeout: beat %0d not accepted, expected acceptance within 500 cycles", i);
        break;
      end
      @(posedge aclk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    fails++;
    tests++;
    $display("[TB] FAIL global timeout: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    aresetn   = 1'b0;
    tvalid    = 1'b0;
    tdata     = '0;
    tlast     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("reset tready",    32'(tready),     32'd0);
    checkOutput("reset out_valid", 32'(out_valid),  32'd0);
    checkOutput("reset out_data",  out_data,        32'd0);
    checkOutput("reset frame_len", 32'(frame_len),  32'd0);
    checkOutput("reset busy",      32'(busy),       32'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    $display("[TB] nominal 40-beat frame");
    applyStimulus(40, 0, -1, -1);
    checkOutput("nominal frame_done", 32'(frame_done), 32'd1);
    checkOutput("nominal frame_len",  32'(frame_len),  32'd40);
    checkOutput("nominal len_err",    32'(len_err),    32'd0);
    @(posedge aclk); #1;
    checkOutput("nominal done pulse ends", 32'(frame_done), 32'd0);
    repeat (10) @(posedge aclk); #1;

    $display("[TB] backpressure and full-plus-pop");
    out_ready = 1'b0;
    accepted  = 0;
    got.delete();
    logging   = 1'b1;
    fork
      applyStimulus(40, 0, -1, -1);
      begin
        repeat (20) @(posedge aclk); #1;
        checkOutput("full accepted",  32'(accepted),  32'd8);
        checkOutput("full tready",    32'(tready),    32'd0);
        checkOutput("full out_valid", 32'(out_valid), 32'd1);
        checkOutput("full out_data",  out_data,       32'd0);
        out_ready = 1'b1;
        @(posedge aclk); #1;
        out_ready = 1'b0;
        checkOutput("pop tready",     32'(tready),    32'd1);
        checkOutput("pop out_data",   out_data,       32'd1);
        checkOutput("pop accepted",   32'(accepted),  32'd8);
        @(posedge aclk); #1;
        checkOutput("refill accepted", 32'(accepted), 32'd9);
        checkOutput("refill tready",   32'(tready),   32'd0);
        out_ready = 1'b1;
      end
    join
    repeat (15) @(posedge aclk); #1;
    logging = 1'b0;
    checkOutput("drain count", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size() && i < 40; i++) begin
      logic [DATA_W:0] beat;
      beat = got[i];
      checkOutput("drain data", beat[DATA_W-1:0], 32'(i));
      checkOutput("drain last", 32'(beat[DATA_W]), 32'(i == 39));
    end

    $display("[TB] enable pause at beat 20");
    accepted = 0;
    logging  = 1'b1;
    applyStimulus(40, 200, 20, -1);
    logging  = 1'b0;
    checkOutput("pause accepted",  32'(accepted),  32'd40);
    checkOutput("pause frame_len", 32'(frame_len), 32'd40);
    checkOutput("pause len_err",   32'(len_err),   32'd0);
    repeat (5) @(posedge aclk); #1;

    $display("[TB] short frames");
    applyStimulus(5, 300, -1, -1);
    checkOutput("short5 frame_done", 32'(frame_done), 32'd1);
    checkOutput("short5 frame_len",  32'(frame_len),  32'd5);
    checkOutput("short5 len_err",    32'(len_err),    32'd1);
    applyStimulus(1, 400, -1, -1);
    checkOutput("single frame_done", 32'(frame_done), 32'd1);
    checkOutput("single frame_len",  32'(frame_len),  32'd1);
    checkOutput("single busy",       32'(busy),       32'd0);
    repeat (5) @(posedge aclk); #1;

    $display("[TB] reset mid-frame");
    applyStimulus(40, 500, -1, 20);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    aresetn = 1'b0;
    #1;
    checkOutput("abort tready",     32'(tready),     32'd0);
    checkOutput("abort out_valid",  32'(out_valid),  32'd0);
    checkOutput("abort busy",       32'(busy),       32'd0);
    checkOutput("abort frame_done", 32'(frame_done), 32'd0);
    checkOutput("abort frame_len",  32'(frame_len),  32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (3) @(posedge aclk); #1;
    checkOutput("post-reset frame_done", 32'(frame_done), 32'd0);
    applyStimulus(40, 600, -1, -1);
    checkOutput("fresh frame_done", 32'(frame_done), 32'd1);
    checkOutput("fresh frame_len",  32'(frame_len),  32'd40);
    checkOutput("fresh len_err",    32'(len_err),    32'd0);
    repeat (15) @(posedge aclk); #1;
    checkOutput("final out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_s.md
Name: axis_s

Overview:
- AXI-Stream receiver (slave end) for the axis_m transmitter.
- Accepts tvalid/tdata/tlast beats and buffers them in a small first-word-fall-through FIFO.
- Presents the buffered beats on a valid/ready drain port.
- Tracks frame boundaries and reports per-frame length, checking it against the expected burst length.

Parameters:
DATA_W, 32, width of tdata and out_data
DEPTH, 8, FIFO depth in beats; power of 2, at least 2
EXP_LEN, 40, expected beats per frame for length check

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
tvalid  input  1  AXI-Stream beat valid from transmitter
tready  output  1  AXI-Stream ready to transmitter
tdata  input  DATA_W  AXI-Stream beat data
tlast  input  1  last beat of frame
enable  input  1  receiver enable; gates tready
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream consumes head when high with out_valid
out_data  output  DATA_W  FIFO head data
out_last  output  1  tlast stored with head beat
frame_done  output  1  one-cycle pulse per completed frame
frame_len  output  16  beat count of last completed frame
len_err  output  1  last completed frame length != EXP_LEN
busy  output  1  high while mid-frame (FSM in RECV)

Behaviour:
- Reset (aresetn low, asynchronous): FIFO emptied (pointers and count 0), FSM in IDLE, beat_cnt 0.
- Reset output values: tready 0, out_valid 0, out_data 0, out_last 0, frame_done 0, frame_len 0, len_err 0, busy 0.
- Ready:
  - tready = enable AND (count < DEPTH), decoded from registered state only.
  - No combinational path from out_ready or tvalid to tready.
- Accept: a beat is accepted when tvalid AND tready at the rising edge. {tlast, tdata} is written to the FIFO tail, and count increments unless a pop happens in the same cycle.
- Drain: out_valid = (count != 0). out_data/out_last show the head with zero read latency. Pop when out_valid AND out_ready.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, no push is possible that cycle because tready was 0. tready rises on the cycle after the pop.
  - When empty, a pushed beat appears on out_valid the cycle after acceptance, never in the same cycle.
- Pointers wrap modulo DEPTH. Each accepted beat is delivered exactly once, in order.
- enable low mid-frame: tready drops. FSM state and beat_cnt are held, and the frame resumes when enable returns. A transmitter holding tvalid/tdata sees exactly one acceptance.
- FSM:
  - IDLE: on an accepted beat with tlast=0, go to RECV with beat_cnt=1. On an accepted beat with tlast=1 (single-beat frame), stay in IDLE and complete a frame of length 1.
  - RECV: on an accepted beat with tlast=0, beat_cnt+1 (saturating at 65535). On an accepted beat with tlast=1, complete the frame, set beat_cnt to 0 and go to IDLE.
- busy = (state == RECV).
- Frame completion:
  - On the edge where the tlast beat is accepted, register frame_len = beat_cnt+1 (saturated) and len_err = (frame_len != EXP_LEN).
  - frame_done is high for exactly the following cycle.
  - frame_len and len_err hold until the next completion.
  - Back-to-back frames give back-to-back frame_done pulses with no lost frames.
- Saturation: a frame longer than 65535 beats reports frame_len=65535 and len_err=1.
- Reset mid-frame: all state is discarded immediately, including the partial frame and buffered beats. No frame_done is generated for the aborted frame.

Test Plan:
- 40-beat frame, tdata 0..39, tlast on beat 40, out_ready=1 -> out_data 0..39 in order with out_last on 39; frame_done pulses one cycle after the beat-40 handshake; frame_len=40, len_err=0; busy high from after beat 1 through the beat-40 edge.
- Backpressure: out_ready=0, transmitter streams continuously -> exactly 8 beats accepted, tready=0, out_valid=1 with out_data=0. Then out_ready=1 -> 0..39 delivered with no loss or duplication.
- Full plus pop: count=8, tvalid=1, out_ready=1 for one cycle -> no push that cycle, count=7, tready=1 next cycle, next beat accepted.
- enable pulsed low for 1 cycle at beat 20, tvalid/tdata=20 held -> value 20 accepted once; frame_len=40, len_err=0.
- Short frames: a 5-beat frame -> frame_len=5, len_err=1. Then a 1-beat frame -> frame_done, frame_len=1, busy never high.
- aresetn low for 2 cycles after beat 20 -> tready, out_valid, busy and frame_done go 0 immediately, and no frame_done follows. After release, a fresh 40-beat frame gives frame_len=40, len_err=0.
